// File: rtl/serializer_p2s.sv
// Parallel-to-serial PHY stage: one-byte buffer, MSB-first shifter,
// COM fill on idle slots and a COM training run after reset.
module serializer_p2s #(
    parameter int                DATA_W  = 8,
    parameter logic [DATA_W-1:0] COM_SYM = 8'hBC,
    parameter int                MIN_COM = 4
) (
    input  logic              clk,
    input  logic              reset_L,
    input  logic [DATA_W-1:0] data_in,
    input  logic              valid_in,
    output logic              ready_out,
    output logic              data_out,
    output logic              sym_start,
    output logic              is_data
);

    typedef enum logic {
        TRAIN,
        DATA
    } state_t;

    localparam logic [2:0] MSB      = 3'(DATA_W - 1);
    localparam logic [3:0] LAST_COM = 4'(MIN_COM - 1);

    state_t            state_q;
    state_t            state_d;
    logic [DATA_W-1:0] sym_q;
    logic [DATA_W-1:0] buf_q;
    logic [2:0]        cnt_q;
    logic [3:0]        com_cnt;
    logic              buf_full;
    logic              sym_data;
    logic              boundary;
    logic              accept;

    assign boundary  = (cnt_q == MSB);
    assign ready_out = (state_q == DATA) && !buf_full;
    assign accept    = valid_in && ready_out;

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            state_q <= TRAIN;
        end else begin
            state_q <= state_d;
        end
    end

    // Leave training on the boundary that completes the last COM
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            TRAIN: begin
                if (boundary && com_cnt == LAST_COM) begin
                    state_d = DATA;
                end
            end
            DATA: state_d = DATA;
        endcase
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            sym_q     <= COM_SYM;
            buf_q     <= '0;
            cnt_q     <= '0;
            com_cnt   <= '0;
            buf_full  <= 1'b0;
            sym_data  <= 1'b0;
            data_out  <= 1'b0;
            sym_start <= 1'b0;
            is_data   <= 1'b0;
        end else begin
            data_out  <= sym_q[MSB - cnt_q];
            sym_start <= (cnt_q == 3'd0);
            is_data   <= sym_data;
            cnt_q     <= cnt_q + 3'd1;
            if (boundary) begin
                if (state_q == DATA && buf_full) begin
                    sym_q    <= buf_q;
                    sym_data <= 1'b1;
                    buf_full <= 1'b0;
                end else begin
                    sym_q    <= COM_SYM;
                    sym_data <= 1'b0;
                end
            end
            if (state_q == TRAIN && boundary) begin
                com_cnt <= com_cnt + 4'd1;
            end
            // A same-edge accept wins over the boundary release
            if (accept) begin
                buf_q    <= data_in;
                buf_full <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_serializer_p2s.sv
// Randomized scoreboard bench for serializer_p2s: a driver predicts
// acceptance and symbol start times, a monitor reassembles symbols.
module tb_serializer_p2s;

    localparam int MIN_COM = 4;
    localparam int T       = 8 * MIN_COM;

    logic       clk      = 1'b0;
    logic       reset_L  = 1'b0;
    logic [7:0] data_in  = 8'h00;
    logic       valid_in = 1'b0;
    logic       ready_out;
    logic       data_out;
    logic       sym_start;
    logic       is_data;

    serializer_p2s #(
        .DATA_W (8),
        .COM_SYM(8'hBC),
        .MIN_COM(MIN_COM)
    ) dut (
        .clk      (clk),
        .reset_L  (reset_L),
        .data_in  (data_in),
        .valid_in (valid_in),
        .ready_out(ready_out),
        .data_out (data_out),
        .sym_start(sym_start),
        .is_data  (is_data)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // edges since reset release; edge n carries bit (n-1)%8 of symbol (n-1)/8
    int n;
    always @(posedge clk or negedge reset_L) begin
        if (!reset_L) n <= 0;
        else          n <= n + 1;
    end

    typedef struct {
        logic [7:0] b;
        int         st;
    } exp_t;

    exp_t exp_q[$];
    bit   pending = 1'b0;
    bit   mready  = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] want);
        tests++;
        if (act !== want) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at edge %0d",
                     nm, act, want, n);
        end
    endtask

    task automatic fail_now(input string nm);
        tests++;
        fails++;
        $display("FAIL %s at edge %0d", nm, n);
    endtask

    // One clock: drive inputs, let the edge happen, update the model
    task automatic cycle(input bit v, input logic [7:0] d);
        bit acc;
        valid_in = v;
        data_in  = d;
        acc      = v && mready;
        @(posedge clk);
        #1;
        if (n % 8 == 0 && n > T && pending) pending = 1'b0;
        if (acc) begin
            pending = 1'b1;
            exp_q.push_back(exp_t'{b: d, st: (n / 8 + 1) * 8 + 1});
        end
        mready = (n >= T) && !pending;
        chk("ready_out", ready_out, mready);
    endtask

    // Idle until the model is ready and the next edge has (edge%8)==ph
    task automatic wait_ready(input int ph);
        int k = 0;
        while (!(mready && (ph < 0 || (n + 1) % 8 == ph)) && k < 64) begin
            cycle(1'b0, 8'h00);
            k++;
        end
        if (k >= 64) fail_now("wait_ready_timeout");
    endtask

    task automatic do_reset();
        valid_in = 1'b0;
        #3;
        reset_L = 1'b0;
        #1;
        chk("rst_outs", {data_out, sym_start, is_data, ready_out}, 4'b0000);
        exp_q.delete();
        pending = 1'b0;
        mready  = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        reset_L = 1'b1;
    endtask

    initial begin
        #12;
        chk("reset_state", {data_out, sym_start, is_data, ready_out}, 4'b0000);
        @(posedge clk);
        #2;
        reset_L = 1'b1;
        cycle(1'b0, 8'h00);
        chk("first_msb", {sym_start, data_out, is_data}, 3'b110);
        repeat (T + 15) cycle(1'b0, 8'h00);

        wait_ready(-1);
        cycle(1'b1, 8'hA5);
        repeat (24) cycle(1'b0, 8'h00);

        for (int i = 1; i <= 3; i++) begin
            wait_ready(-1);
            cycle(1'b1, 8'(i));
        end
        repeat (24) cycle(1'b0, 8'h00);

        repeat (48) cycle(1'b1, mready ? 8'($urandom) : 8'hFF);
        repeat (16) cycle(1'b0, 8'h00);

        wait_ready(7);
        cycle(1'b1, 8'($urandom));
        repeat (16) cycle(1'b0, 8'h00);
        wait_ready(0);
        cycle(1'b1, 8'($urandom));
        repeat (20) cycle(1'b0, 8'h00);

        repeat (400) cycle(1'($urandom_range(0, 1)), 8'($urandom));
        repeat (16) cycle(1'b0, 8'h00);

        wait_ready(-1);
        cycle(1'b1, 8'h3C);
        wait_ready(-1);
        cycle(1'b1, 8'hC3);
        repeat (3) cycle(1'b0, 8'h00);
        do_reset();
        repeat (T + 24) cycle(1'b0, 8'h00);

        wait_ready(-1);
        cycle(1'b1, 8'h5A);
        repeat (20) cycle(1'b0, 8'h00);
        chk("sb_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Monitor: rebuild each symbol and score it against the queue
    initial begin
        bit         col = 1'b0;
        bit         sd  = 1'b0;
        logic [7:0] sh  = 8'h00;
        int         nb  = 0;
        int         st  = 0;
        exp_t       e;
        forever begin
            @(posedge clk);
            #1;
            if (!reset_L) begin
                col = 1'b0;
            end else begin
                chk("sym_start", sym_start, ((n - 1) % 8 == 0));
                if (sym_start) begin
                    col = 1'b1;
                    sd  = is_data;
                    sh  = 8'h00;
                    nb  = 0;
                    st  = n;
                end
                if (col) begin
                    chk("is_data", is_data, sd);
                    sh = {sh[6:0], data_out};
                    nb++;
                    if (nb == 8) begin
                        col = 1'b0;
                        if (sd) begin
                            if (exp_q.size() == 0) begin
                                fail_now("extra_data");
                            end else begin
                                e = exp_q.pop_front();
                                chk("data_byte", sh, e.b);
                                chk("latency", st, e.st);
                            end
                        end else begin
                            chk("com_sym", sh, 8'hBC);
                            if (exp_q.size() > 0 && exp_q[0].st == st)
                                fail_now("missing_data");
                        end
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
